// File: rtl/tff_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tff_updown_counter
// Brief    : WIDTH-bit up/down counter with toggle-style enable, modulus,
//            wrap/saturate boundary mode, terminal-count and overflow flags.
// Revision : 1.0
// ============================================================================
module tff_updown_counter #(
    parameter int                  WIDTH    = 4,
    parameter logic [WIDTH-1:0]    MAX_VAL  = {WIDTH{1'b1}},
    parameter bit                  SATURATE = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] Q,
    output logic             tc,
    output logic             ovf
);

    localparam logic [WIDTH-1:0] c_one      = WIDTH'(1);
    localparam logic [WIDTH-1:0] c_zero     = '0;
    // Value taken when a count step hits a boundary in each direction.
    localparam logic [WIDTH-1:0] c_top_wrap = SATURATE ? MAX_VAL : c_zero;
    localparam logic [WIDTH-1:0] c_bot_wrap = SATURATE ? c_zero  : MAX_VAL;

    logic [WIDTH-1:0] r_q;
    logic             r_ovf;

    logic             w_at_max;
    logic             w_at_zero;
    logic             w_over;
    logic [WIDTH-1:0] w_load_val;
    logic [WIDTH-1:0] w_q_next;
    logic             w_ovf_next;

    assign w_at_max  = (r_q == MAX_VAL);
    assign w_at_zero = (r_q == c_zero);

    // A full-range modulus can never hold an out-of-range value or need clamping.
    generate
        if (MAX_VAL == {WIDTH{1'b1}}) begin : g_full_range
            assign w_over     = 1'b0;
            assign w_load_val = d;
        end else begin : g_part_range
            assign w_over     = (r_q > MAX_VAL);
            assign w_load_val = (d > MAX_VAL) ? MAX_VAL : d;
        end
    endgenerate

    always_comb begin
        w_q_next   = r_q;
        w_ovf_next = 1'b0;
        if (clr) begin
            w_q_next = c_zero;
        end else if (load) begin
            w_q_next = w_load_val;
        end else if (en) begin
            if (up) begin
                if (w_over) begin
                    w_q_next   = c_zero;
                    w_ovf_next = 1'b1;
                end else if (w_at_max) begin
                    w_q_next   = c_top_wrap;
                    w_ovf_next = 1'b1;
                end else begin
                    w_q_next = r_q + c_one;
                end
            end else begin
                if (w_over) begin
                    w_q_next   = MAX_VAL;
                    w_ovf_next = 1'b1;
                end else if (w_at_zero) begin
                    w_q_next   = c_bot_wrap;
                    w_ovf_next = 1'b1;
                end else begin
                    w_q_next = r_q - c_one;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q   <= c_zero;
            r_ovf <= 1'b0;
        end else begin
            r_q   <= w_q_next;
            r_ovf <= w_ovf_next;
        end
    end

    assign Q   = r_q;
    assign ovf = r_ovf;
    // Terminal count looks only at the counting path; clr/load do not mask it.
    assign tc  = en & ~rst & ((up & w_at_max) | (~up & w_at_zero));

endmodule
`default_nettype wire

// File: tb/tb_tff_updown_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_tff_updown_counter
// Brief    : Self-checking bench for tff_updown_counter in three configurations.
// Revision : 1.0
// ============================================================================
module tb_tff_updown_counter;

    logic       clk = 1'b0;
    logic       rst, clr, load, en, up;
    logic [3:0] d;

    logic       q0;
    logic [3:0] q1, q2;
    logic       tc0, tc1, tc2;
    logic       ovf0, ovf1, ovf2;

    logic [3:0] q_obs   [3];
    logic       tc_obs  [3];
    logic       ovf_obs [3];

    assign q_obs[0]   = {3'b000, q0};
    assign q_obs[1]   = q1;
    assign q_obs[2]   = q2;
    assign tc_obs[0]  = tc0;
    assign tc_obs[1]  = tc1;
    assign tc_obs[2]  = tc2;
    assign ovf_obs[0] = ovf0;
    assign ovf_obs[1] = ovf1;
    assign ovf_obs[2] = ovf2;

    always #5 clk = ~clk;

    // Plain T flip-flop configuration.
    tff_updown_counter #(.WIDTH(1)) u_dut0 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d[0:0]),
        .en(en), .up(up), .Q(q0), .tc(tc0), .ovf(ovf0)
    );

    // Decade counter, wrapping.
    tff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
        .en(en), .up(up), .Q(q1), .tc(tc1), .ovf(ovf1)
    );

    // Decade counter, saturating.
    tff_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9), .SATURATE(1'b1)) u_dut2 (
        .clk(clk), .rst(rst), .clr(clr), .load(load), .d(d),
        .en(en), .up(up), .Q(q2), .tc(tc2), .ovf(ovf2)
    );

    int errors = 0;
    int checks = 0;

    // Reference model: count value as an integer per configuration.
    int m_q   [3];
    bit m_ovf [3];
    int c_max [3] = '{1, 9, 9};
    bit c_sat [3] = '{1'b0, 1'b0, 1'b1};
    int c_mod [3] = '{2, 16, 16};

    function automatic bit exp_tc(int k);
        return en && !rst && ((up && m_q[k] == c_max[k]) || (!up && m_q[k] == 0));
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_q[k]   = 0;
            m_ovf[k] = 1'b0;
        end
    endtask

    // One rising edge, model update, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            int dv;
            m_ovf[k] = 1'b0;
            if (rst || clr) begin
                m_q[k] = 0;
            end else if (load) begin
                dv = int'(d) % c_mod[k];
                m_q[k] = (dv > c_max[k]) ? c_max[k] : dv;
            end else if (en && up) begin
                if (m_q[k] == c_max[k]) begin
                    m_ovf[k] = 1'b1;
                    m_q[k]   = c_sat[k] ? c_max[k] : 0;
                end else begin
                    m_q[k] = m_q[k] + 1;
                end
            end else if (en) begin
                if (m_q[k] == 0) begin
                    m_ovf[k] = 1'b1;
                    m_q[k]   = c_sat[k] ? 0 : c_max[k];
                end else begin
                    m_q[k] = m_q[k] - 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1; clr = 1'b0; load = 1'b0; en = 1'b1; up = 1'b0; d = 4'd0;
        model_reset();
        #6;
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (q_obs[k] !== 4'd0) begin
                errors++; $display("FAIL reset_q dut%0d: got %0d expected 0", k, q_obs[k]);
            end
            if (ovf_obs[k] !== 1'b0) begin
                errors++; $display("FAIL reset_ovf dut%0d: got %0b expected 0", k, ovf_obs[k]);
            end
            if (tc_obs[k] !== 1'b0) begin
                errors++; $display("FAIL reset_tc dut%0d: got %0b expected 0", k, tc_obs[k]);
            end
        end
        #1;
        rst = 1'b0; en = 1'b0; up = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_toggle();
        bit en_pat [8] = '{0, 0, 1, 1, 1, 1, 0, 0};
        bit exp_q  [8] = '{0, 0, 1, 0, 1, 0, 0, 0};
        bit exp_o  [8] = '{0, 0, 0, 1, 0, 1, 0, 0};
        up = 1'b1;
        for (int i = 0; i < 8; i++) begin
            en = en_pat[i];
            tick();
            checks += 2;
            if (q0 !== exp_q[i]) begin
                errors++; $display("FAIL toggle_q step %0d: got %0b expected %0b", i, q0, exp_q[i]);
            end
            if (ovf0 !== exp_o[i]) begin
                errors++; $display("FAIL toggle_ovf step %0d: got %0b expected %0b", i, ovf0, exp_o[i]);
            end
        end
    endtask

    task automatic test_wrap_up();
        int exp_q [12] = '{1, 2, 3, 4, 5, 6, 7, 8, 9, 0, 1, 2};
        rst = 1'b1; #1; rst = 1'b0;
        model_reset();
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 12; i++) begin
            #1;
            checks++;
            if (tc1 !== (i == 9)) begin
                errors++; $display("FAIL wrap_up_tc step %0d: got %0b expected %0b", i, tc1, (i == 9));
            end
            tick();
            checks += 2;
            if (q1 !== 4'(exp_q[i])) begin
                errors++; $display("FAIL wrap_up_q step %0d: got %0d expected %0d", i, q1, exp_q[i]);
            end
            if (ovf1 !== (i == 9)) begin
                errors++; $display("FAIL wrap_up_ovf step %0d: got %0b expected %0b", i, ovf1, (i == 9));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_wrap_down();
        int exp_q [3] = '{9, 8, 7};
        clr = 1'b1; tick(); clr = 1'b0;
        checks++;
        if (q1 !== 4'd0) begin
            errors++; $display("FAIL clr_q: got %0d expected 0", q1);
        end
        up = 1'b0; en = 1'b1; #1;
        checks++;
        if (tc1 !== 1'b1) begin
            errors++; $display("FAIL wrap_down_tc: got %0b expected 1", tc1);
        end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks += 2;
            if (q1 !== 4'(exp_q[i])) begin
                errors++; $display("FAIL wrap_down_q step %0d: got %0d expected %0d", i, q1, exp_q[i]);
            end
            if (ovf1 !== (i == 0)) begin
                errors++; $display("FAIL wrap_down_ovf step %0d: got %0b expected %0b", i, ovf1, (i == 0));
            end
        end
        en = 1'b0;
    endtask

    task automatic test_saturate();
        en = 1'b0; load = 1'b1; d = 4'd8; tick(); load = 1'b0;
        checks += 2;
        if (q2 !== 4'd8) begin
            errors++; $display("FAIL sat_load_q: got %0d expected 8", q2);
        end
        if (ovf2 !== 1'b0) begin
            errors++; $display("FAIL sat_load_ovf: got %0b expected 0", ovf2);
        end
        up = 1'b1; en = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (tc2 !== (i != 0)) begin
                errors++; $display("FAIL sat_tc step %0d: got %0b expected %0b", i, tc2, (i != 0));
            end
            tick();
            checks += 2;
            if (q2 !== 4'd9) begin
                errors++; $display("FAIL sat_q step %0d: got %0d expected 9", i, q2);
            end
            if (ovf2 !== (i != 0)) begin
                errors++; $display("FAIL sat_ovf step %0d: got %0b expected %0b", i, ovf2, (i != 0));
            end
        end
        load = 1'b1; d = 4'd15; #1;
        checks++;
        if (tc2 !== 1'b1) begin
            errors++; $display("FAIL tc_ignores_load: got %0b expected 1", tc2);
        end
        tick();
        load = 1'b0; en = 1'b0;
        checks += 3;
        if (q2 !== 4'd9) begin
            errors++; $display("FAIL clamp_sat_q: got %0d expected 9", q2);
        end
        if (q1 !== 4'd9) begin
            errors++; $display("FAIL clamp_wrap_q: got %0d expected 9", q1);
        end
        if (ovf2 !== 1'b0) begin
            errors++; $display("FAIL clamp_ovf: got %0b expected 0", ovf2);
        end
    endtask

    task automatic test_priority();
        clr = 1'b1; load = 1'b1; d = 4'd5; en = 1'b1; up = 1'b1;
        tick();
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (q_obs[k] !== 4'd0) begin
                errors++; $display("FAIL prio_clr dut%0d: got %0d expected 0", k, q_obs[k]);
            end
        end
        clr = 1'b0;
        tick();
        load = 1'b0; en = 1'b0;
        checks += 3;
        if (q0 !== 1'b1) begin
            errors++; $display("FAIL prio_load dut0: got %0b expected 1", q0);
        end
        if (q1 !== 4'd5) begin
            errors++; $display("FAIL prio_load dut1: got %0d expected 5", q1);
        end
        if (q2 !== 4'd5) begin
            errors++; $display("FAIL prio_load dut2: got %0d expected 5", q2);
        end
    endtask

    task automatic test_async_reset();
        load = 1'b1; d = 4'd6; tick(); load = 1'b0; en = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (q1 !== 4'd6) begin
            errors++; $display("FAIL async_pre_q: got %0d expected 6", q1);
        end
        #1;
        rst = 1'b1; en = 1'b1; up = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            checks += 3;
            if (q_obs[k] !== 4'd0) begin
                errors++; $display("FAIL async_q dut%0d: got %0d expected 0", k, q_obs[k]);
            end
            if (ovf_obs[k] !== 1'b0) begin
                errors++; $display("FAIL async_ovf dut%0d: got %0b expected 0", k, ovf_obs[k]);
            end
            if (tc_obs[k] !== 1'b0) begin
                errors++; $display("FAIL async_tc dut%0d: got %0b expected 0", k, tc_obs[k]);
            end
        end
        @(negedge clk);
        tick();
        checks++;
        if (q1 !== 4'd0) begin
            errors++; $display("FAIL async_hold_q: got %0d expected 0", q1);
        end
        rst = 1'b0; up = 1'b1;
        tick();
        en = 1'b0;
        checks += 2;
        if (q1 !== 4'd1) begin
            errors++; $display("FAIL async_resume_q: got %0d expected 1", q1);
        end
        if (ovf1 !== 1'b0) begin
            errors++; $display("FAIL async_resume_ovf: got %0b expected 0", ovf1);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst  = ($urandom_range(0, 49) == 0);
            clr  = ($urandom_range(0, 15) == 0);
            load = ($urandom_range(0, 7) == 0);
            en   = ($urandom_range(0, 3) != 0);
            up   = 1'($urandom_range(0, 1));
            d    = 4'($urandom_range(0, 15));
            if (rst) model_reset();
            #1;
            for (int k = 0; k < 3; k++) begin
                checks++;
                if (tc_obs[k] !== exp_tc(k)) begin
                    errors++; $display("FAIL rand_tc dut%0d cycle %0d: got %0b expected %0b", k, i, tc_obs[k], exp_tc(k));
                end
            end
            tick();
            for (int k = 0; k < 3; k++) begin
                checks += 2;
                if (q_obs[k] !== 4'(m_q[k])) begin
                    errors++; $display("FAIL rand_q dut%0d cycle %0d: got %0d expected %0d", k, i, q_obs[k], m_q[k]);
                end
                if (ovf_obs[k] !== m_ovf[k]) begin
                    errors++; $display("FAIL rand_ovf dut%0d cycle %0d: got %0b expected %0b", k, i, ovf_obs[k], m_ovf[k]);
                end
            end
        end
        rst = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    endtask

    initial begin
        test_reset();
        test_toggle();
        test_wrap_up();
        test_wrap_down();
        test_saturate();
        test_priority();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
